conv_axis_pixel_feeder: RTL and testbench

//  AXIS master that streams a stored multi-channel image into the convolution controller's s_axis port.

---
 rtl/conv_axis_pixel_feeder.sv | 212 +++++++++++++++++++++
 tb/tb_conv_axis_pixel_feeder.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_axis_pixel_feeder.sv
`timescale 1ns/1ps
// conv_axis_pixel_feeder
// Streams a stored multi-channel image from a linear frame memory into the
// convolution controller's AXI-Stream slave. Words are channel-interleaved
// (px0c0, px0c1, .., px1c0, ..), with TLAST on the final word of the frame.
// Memory reads (1-cycle synchronous) land in a 2-entry skid FIFO whose head
// drives the stream, so backpressure never drops or duplicates a word.
//
// Ports
//   axi_clk, axi_reset       clock, asynchronous active-high reset
//   start                    1-cycle pulse: latch geometry, begin a frame
//   image_width/height       frame geometry in pixels / rows
//   base_addr                word address of px0c0
//   mem_rd_en/addr/data      frame memory read port (data one cycle after en)
//   m_axis_*                 AXI-Stream master (valid/data/ready/last/keep)
//   busy, done, err          frame in progress, end-of-frame pulse, rejected-start pulse
//
// Optional feature: define CONV_FEED_ROW_LAST_EN to add m_axis_user, which
// flags the last word of every row (and therefore also the frame's last word).

module conv_axis_pixel_feeder #(
    parameter int AXI_BUS_WIDTH  = 32,
    parameter int CHANNELS       = 3,
    parameter int MAX_WIDTH      = 1800,
    parameter int MAX_HEIGHT     = 1800,
    parameter int MEM_ADDR_WIDTH = 24
) (
    input  logic                      axi_clk,
    input  logic                      axi_reset,
    input  logic                      start,
    input  logic [31:0]               image_width,
    input  logic [31:0]               image_height,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
    output logic                      mem_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [AXI_BUS_WIDTH-1:0]  mem_rd_data,
    output logic                      m_axis_valid,
    output logic [AXI_BUS_WIDTH-1:0]  m_axis_data,
    input  logic                      m_axis_ready,
    output logic                      m_axis_last,
    output logic [3:0]                m_axis_keep,
`ifdef CONV_FEED_ROW_LAST_EN
    output logic                      m_axis_user,
`endif
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t                    state_q, state_d;
    logic [31:0]               total_q, total_d;
    logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]               issued_q, issued_d;
    logic [31:0]               sent_q, sent_d;
    logic                      inflight_q, inflight_d;
    logic                      err_q, err_d;
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                occ_q, occ_d;
    logic [AXI_BUS_WIDTH-1:0]  fifo_data_q [2];

    logic        push, pop, issue, too_big;
    logic [2:0]  occ_sum;
    logic [63:0] product;

`ifdef CONV_FEED_ROW_LAST_EN
    logic [31:0] width_q, width_d;
    logic [31:0] x_q, x_d;
    logic [31:0] c_q, c_d;
    logic        inflight_user_q, inflight_user_d;
    logic        fifo_user_q [2];
    logic        row_last_issue;
`endif

    // Data path and read throttle. The occupancy the FIFO will hold once the
    // in-flight word lands, less this cycle's pop, must stay below 2.
    always_comb begin
        push         = inflight_q;
        m_axis_valid = (occ_q != 2'd0);
        pop          = m_axis_valid && m_axis_ready;
        occ_sum      = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
        issue        = (state_q == S_RUN) && (issued_q != total_q) && (occ_sum < 3'd2);
        mem_rd_en    = issue;
        mem_rd_addr  = base_q + issued_q[MEM_ADDR_WIDTH-1:0];
        m_axis_data  = m_axis_valid ? fifo_data_q[rd_ptr_q] : '0;
        m_axis_last  = m_axis_valid && (sent_q == total_q - 32'd1);
        m_axis_keep  = m_axis_valid ? 4'hF : 4'h0;
`ifdef CONV_FEED_ROW_LAST_EN
        m_axis_user  = m_axis_valid && fifo_user_q[rd_ptr_q];
`endif
        busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
        done         = (state_q == S_FIN);
        err          = err_q;
        inflight_d   = issue;
        wr_ptr_d     = wr_ptr_q ^ push;
        rd_ptr_d     = rd_ptr_q ^ pop;
        occ_d        = occ_q + {1'b0, push} - {1'b0, pop};
        // The high half only matters if the size limits are ever raised
        // enough for the frame word count to overflow 32 bits.
        product      = 64'(image_width) * 64'(image_height) * 64'(CHANNELS);
        too_big      = (image_width > 32'(MAX_WIDTH)) || (image_height > 32'(MAX_HEIGHT))
                       || (|product[63:32]);
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        total_d  = total_q;
        base_d   = base_q;
        issued_d = issued_q + {31'b0, issue};
        sent_d   = sent_q + {31'b0, pop};
        err_d    = 1'b0;
`ifdef CONV_FEED_ROW_LAST_EN
        width_d         = width_q;
        x_d             = x_q;
        c_d             = c_q;
        row_last_issue  = (c_q == 32'(CHANNELS - 1)) && (x_q == width_q - 32'd1);
        inflight_user_d = row_last_issue;
        if (issue) begin
            if (c_q == 32'(CHANNELS - 1)) begin
                c_d = '0;
                x_d = (x_q == width_q - 32'd1) ? '0 : x_q + 32'd1;
            end else begin
                c_d = c_q + 32'd1;
            end
        end
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((image_width == 32'd0) || (image_height == 32'd0)) begin
                        state_d = S_FIN;
                    end else if (too_big) begin
                        err_d = 1'b1;
                    end else begin
                        total_d  = product[31:0];
                        base_d   = base_addr;
                        issued_d = '0;
                        sent_d   = '0;
                        state_d  = S_RUN;
`ifdef CONV_FEED_ROW_LAST_EN
                        width_d  = image_width;
                        x_d      = '0;
                        c_d      = '0;
`endif
                    end
                end
            end
            S_RUN:   if (issued_q == total_q) state_d = S_DRAIN;
            // Using sent_d lets done follow the final beat by one cycle.
            S_DRAIN: if (sent_d == total_q) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge value of every other flop.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q    <= S_IDLE;
            total_q    <= '0;
            base_q     <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= '0;
`ifdef CONV_FEED_ROW_LAST_EN
            width_q         <= '0;
            x_q             <= '0;
            c_q             <= '0;
            inflight_user_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            base_q     <= base_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
`ifdef CONV_FEED_ROW_LAST_EN
            width_q         <= width_d;
            x_q             <= x_d;
            c_q             <= c_d;
            inflight_user_q <= inflight_user_d;
`endif
        end
    end

    // NOTE: FIFO storage is not reset; an empty FIFO never exposes it
    // because the outputs are gated by occupancy.
    always_ff @(posedge axi_clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_rd_data;
`ifdef CONV_FEED_ROW_LAST_EN
            fifo_user_q[wr_ptr_q] <= inflight_user_q;
`endif
        end
    end

endmodule

// File: tb/tb_conv_axis_pixel_feeder.sv
`timescale 1ns/1ps
module tb_conv_axis_pixel_feeder;

    logic        axi_clk = 1'b0;
    logic        axi_reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] image_width = '0;
    logic [31:0] image_height = '0;
    logic [23:0] base_addr = '0;
    logic        mem_rd_en;
    logic [23:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        m_axis_valid;
    logic [31:0] m_axis_data;
    logic        m_axis_ready;
    logic        m_axis_last;
    logic [3:0]  m_axis_keep;
`ifdef CONV_FEED_ROW_LAST_EN
    logic        m_axis_user;
`endif
    logic        busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    conv_axis_pixel_feeder dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset), .start(start),
        .image_width(image_width), .image_height(image_height), .base_addr(base_addr),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data), .m_axis_ready(m_axis_ready),
        .m_axis_last(m_axis_last), .m_axis_keep(m_axis_keep),
`ifdef CONV_FEED_ROW_LAST_EN
        .m_axis_user(m_axis_user),
`endif
        .busy(busy), .done(done), .err(err)
    );

    always #5 axi_clk = ~axi_clk;

    // Frame memory model: mem[a] = a, one-cycle read latency.
    always @(posedge axi_clk) if (mem_rd_en) mem_rd_data <= {8'h00, mem_rd_addr};

    // Ready driver: fixed level or ~50% random.
    logic rand_ready  = 1'b0;
    logic ready_level = 1'b1;
    always @(posedge axi_clk) begin
        #1;
        m_axis_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end

    // Monitor: samples on the falling edge, away from the active edge.
    int          cyc = 0;
    logic [31:0] beats[$];
    logic        lasts[$];
    logic        users[$];
    int          beat_cyc[$];
    int          rd_cnt = 0, rd_oor = 0, done_cnt = 0, done_cyc = 0;
    int          err_cnt = 0, busy_seen = 0, valid_seen = 0, stall_err = 0;
    logic        stalled = 1'b0;
    logic [31:0] st_data;
    logic        st_last;

    always @(posedge axi_clk) cyc <= cyc + 1;

    always @(negedge axi_clk) begin
        if (axi_reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled && (!m_axis_valid || m_axis_data !== st_data || m_axis_last !== st_last))
                stall_err++;
            if (m_axis_valid && m_axis_ready) begin
                beats.push_back(m_axis_data);
                lasts.push_back(m_axis_last);
`ifdef CONV_FEED_ROW_LAST_EN
                users.push_back(m_axis_user);
`else
                users.push_back(1'b0);
`endif
                beat_cyc.push_back(cyc);
            end
            stalled = m_axis_valid && !m_axis_ready;
            st_data = m_axis_data;
            st_last = m_axis_last;
            if (mem_rd_en) begin
                rd_cnt++;
                if (mem_rd_addr < 24'h100 || mem_rd_addr > 24'h123) rd_oor++;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) err_cnt++;
            if (busy) busy_seen++;
            if (m_axis_valid) valid_seen++;
        end
    end

    task automatic step(int n);
        repeat (n) begin @(posedge axi_clk); #1; end
    endtask

    task automatic pulse_start(logic [31:0] w, logic [31:0] h, logic [23:0] b);
        image_width = w; image_height = h; base_addr = b; start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(string name, int budget);
        int k = 0;
        while (!done && k < budget) begin step(1); k++; end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, k);
        end
    endtask

    task automatic wait_beats(string name, int b0, int count, int budget);
        int k = 0;
        while (beats.size() - b0 < count && k < budget) begin step(1); k++; end
        n_checks++;
        if (beats.size() - b0 < count) begin
            n_fail++;
            $display("FAIL %s_beats_timeout: got %0d beats, required %0d", name, beats.size() - b0, count);
        end
    endtask

    // 4x3x3 frame at base 0x100: 36 consecutive words, last on index 35,
    // row-last flag on indices 11, 23, 35.
    task automatic verify_frame(string name, int b0);
        int n = beats.size() - b0;
        int data_bad = 0, last_bad = 0, user_bad = 0;
        n_checks++;
        if (n !== 36) begin
            n_fail++;
            $display("FAIL %s_count: got %0d beats, required 36", name, n);
        end
        for (int i = 0; i < n; i++) begin
            if (beats[b0+i] !== 32'h100 + 32'(i)) data_bad++;
            if (lasts[b0+i] !== (i == 35)) last_bad++;
            if (users[b0+i] !== ((i % 12) == 11)) user_bad++;
        end
        n_checks++;
        if (data_bad != 0) begin
            n_fail++;
            $display("FAIL %s_data: %0d words wrong (first word 0x%0h), required 0x100..0x123", name, data_bad,
                     (n > 0) ? beats[b0] : 32'hx);
        end
        n_checks++;
        if (last_bad != 0) begin
            n_fail++;
            $display("FAIL %s_last: %0d beats with wrong TLAST, required 0", name, last_bad);
        end
`ifdef CONV_FEED_ROW_LAST_EN
        n_checks++;
        if (user_bad != 0) begin
            n_fail++;
            $display("FAIL %s_user: %0d beats with wrong row-last flag, required 0", name, user_bad);
        end
`endif
    endtask

    task automatic test_reset();
        axi_reset = 1'b1;
        step(2);
        n_checks++;
        if ({m_axis_valid, m_axis_last, busy, done, err, mem_rd_en} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid,last,busy,done,err,rd_en=%b required 000000",
                     {m_axis_valid, m_axis_last, busy, done, err, mem_rd_en});
        end
        n_checks++;
        if (m_axis_data !== 32'h0 || m_axis_keep !== 4'h0 || mem_rd_addr !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_data: data=0x%0h keep=0x%0h addr=0x%0h required all 0",
                     m_axis_data, m_axis_keep, mem_rd_addr);
        end
        axi_reset = 1'b0;
        step(2);
    endtask

    task automatic test_basic();
        int b0 = beats.size(), r0 = rd_cnt, o0 = rd_oor, d0 = done_cnt, lat = 0;
        ready_level = 1'b1;
        step(1);
        pulse_start(4, 3, 24'h100);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: busy=%b the cycle after start, required 1", busy);
        end
        while (!m_axis_valid && lat < 10) begin step(1); lat++; end
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL basic_latency: first valid %0d cycles after start, required 3", lat + 1);
        end
        n_checks++;
        if (m_axis_keep !== 4'hF) begin
            n_fail++;
            $display("FAIL basic_keep: keep=0x%0h while valid, required 0xf", m_axis_keep);
        end
        wait_done("basic", 200);
        step(1);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after: busy=%b done=%b, required 0 0", busy, done);
        end
        verify_frame("basic", b0);
        if (beats.size() - b0 == 36) begin
            n_checks++;
            if (beat_cyc[b0+35] - beat_cyc[b0] !== 35) begin
                n_fail++;
                $display("FAIL basic_throughput: 36 beats over %0d cycles, required 36",
                         beat_cyc[b0+35] - beat_cyc[b0] + 1);
            end
            n_checks++;
            if (done_cyc !== beat_cyc[b0+35] + 1) begin
                n_fail++;
                $display("FAIL basic_done_time: done at cycle %0d, required %0d", done_cyc, beat_cyc[b0+35] + 1);
            end
        end
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL basic_done_count: %0d done pulses, required 1", done_cnt - d0);
        end
        n_checks++;
        if (rd_cnt - r0 !== 36 || rd_oor - o0 !== 0) begin
            n_fail++;
            $display("FAIL basic_reads: %0d reads, %0d outside frame, required 36 and 0", rd_cnt - r0, rd_oor - o0);
        end
    endtask

    task automatic test_backpressure();
        int b0 = beats.size(), r0 = rd_cnt, o0 = rd_oor, s0 = stall_err;
        rand_ready = 1'b1;
        pulse_start(4, 3, 24'h100);
        wait_done("bp", 1000);
        rand_ready = 1'b0;
        step(2);
        verify_frame("bp", b0);
        n_checks++;
        if (stall_err - s0 !== 0) begin
            n_fail++;
            $display("FAIL bp_stable: %0d stalls changed valid/data/last, required 0", stall_err - s0);
        end
        n_checks++;
        if (rd_cnt - r0 !== 36 || rd_oor - o0 !== 0) begin
            n_fail++;
            $display("FAIL bp_reads: %0d reads, %0d outside frame, required 36 and 0", rd_cnt - r0, rd_oor - o0);
        end
    endtask

    task automatic test_zero();
        int d0 = done_cnt, v0 = valid_seen, r0 = rd_cnt;
        pulse_start(0, 5, 24'h100);
        step(2);
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL zero_done: %0d done pulses within 2 cycles, required 1", done_cnt - d0);
        end
        n_checks++;
        if (valid_seen - v0 !== 0 || rd_cnt - r0 !== 0) begin
            n_fail++;
            $display("FAIL zero_quiet: %0d valid cycles, %0d reads, required 0 and 0", valid_seen - v0, rd_cnt - r0);
        end
    endtask

    task automatic test_oversize();
        int e0 = err_cnt, bs0 = busy_seen, r0 = rd_cnt;
        pulse_start(1801, 3, 24'h100);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL oversize_err: err=%b the cycle after start, required 1", err);
        end
        step(2);
        pulse_start(4, 1801, 24'h100);
        step(3);
        n_checks++;
        if (err_cnt - e0 !== 2) begin
            n_fail++;
            $display("FAIL oversize_err_count: %0d err pulses, required 2", err_cnt - e0);
        end
        n_checks++;
        if (busy_seen - bs0 !== 0 || rd_cnt - r0 !== 0) begin
            n_fail++;
            $display("FAIL oversize_quiet: %0d busy cycles, %0d reads, required 0 and 0", busy_seen - bs0, rd_cnt - r0);
        end
    endtask

    task automatic test_restart_ignored();
        int b0 = beats.size(), o0 = rd_oor;
        pulse_start(4, 3, 24'h100);
        wait_beats("restart", b0, 5, 50);
        pulse_start(1, 1, 24'h000);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_busy: busy=%b after mid-frame start, required 1", busy);
        end
        wait_done("restart", 200);
        step(2);
        verify_frame("restart", b0);
        n_checks++;
        if (rd_oor - o0 !== 0) begin
            n_fail++;
            $display("FAIL restart_reads: %0d reads outside frame, required 0", rd_oor - o0);
        end
    endtask

    task automatic test_reset_mid();
        int b0 = beats.size();
        pulse_start(4, 3, 24'h100);
        wait_beats("rstmid", b0, 10, 50);
        axi_reset = 1'b1;
        #1;
        n_checks++;
        if ({m_axis_valid, m_axis_last, busy, done, err, mem_rd_en} !== 6'b0 || m_axis_data !== 32'h0
            || m_axis_keep !== 4'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: valid,last,busy,done,err,rd_en=%b data=0x%0h keep=0x%0h required all 0",
                     {m_axis_valid, m_axis_last, busy, done, err, mem_rd_en}, m_axis_data, m_axis_keep);
        end
        step(2);
        axi_reset = 1'b0;
        step(1);
        b0 = beats.size();
        pulse_start(4, 3, 24'h100);
        wait_done("rstmid", 200);
        step(2);
        verify_frame("rstmid", b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_oversize();
        test_restart_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
